// File: rtl/reorder_buffer_pkg.sv
// Shared RoB definitions used by the reorder buffer, dispatcher and register file.
package reorder_buffer_pkg;

  localparam int RoB_WIDTH    = 8;
  localparam int RoB_SIZE     = 1 << RoB_WIDTH;
  localparam int EX_REG_WIDTH = 6;

  // bit5 set marks "no destination register"
  localparam logic [EX_REG_WIDTH-1:0] NON_REG = 6'b100000;

  // Register-file dependency tag meaning "value is architectural, no RoB producer"
  localparam logic [RoB_WIDTH:0] NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}};

  typedef struct packed {
    logic                    busy;
    logic                    ready;
    logic [EX_REG_WIDTH-1:0] rd;
    logic [31:0]             value;
    logic                    is_br;
    logic                    pred;
    logic                    taken;
    logic [31:0]             alt_pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_entry_array.sv
// RoB entry storage: dispatch and CDB write ports, commit free, flush,
// plus combinational head and operand-forwarding read ports.
module rob_entry_array
  import reorder_buffer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    disp_en,
  input  logic [RoB_WIDTH-1:0]    disp_idx,
  input  logic [EX_REG_WIDTH-1:0] disp_rd,
  input  logic                    disp_is_br,
  input  logic                    disp_pred,
  input  logic [31:0]             disp_alt_pc,
  input  logic                    cdb_en,
  input  logic [RoB_WIDTH-1:0]    cdb_idx,
  input  logic [31:0]             cdb_value,
  input  logic                    cdb_taken,
  input  logic                    free_en,
  input  logic [RoB_WIDTH-1:0]    free_idx,
  input  logic                    flush,
  input  logic [RoB_WIDTH-1:0]    head_idx,
  output rob_entry_t              head_entry,
  input  logic [RoB_WIDTH-1:0]    q1_idx,
  output logic                    q1_rdy,
  output logic [31:0]             q1_val,
  input  logic [RoB_WIDTH-1:0]    q2_idx,
  output logic                    q2_rdy,
  output logic [31:0]             q2_val
);

  rob_entry_t entries_q [RoB_SIZE];
  rob_entry_t entries_d [RoB_SIZE];

  // Next entry contents; a flush wipes every entry and drops same-cycle writes
  always_comb begin
    entries_d = entries_q;
    if (flush) begin
      for (int i = 0; i < RoB_SIZE; i++) begin
        entries_d[i].busy  = 1'b0;
        entries_d[i].ready = 1'b0;
      end
    end else begin
      // a result for an entry that is not allocated is stale and ignored
      if (cdb_en && entries_q[cdb_idx].busy) begin
        entries_d[cdb_idx].ready = 1'b1;
        entries_d[cdb_idx].value = cdb_value;
        entries_d[cdb_idx].taken = cdb_taken;
      end
      if (free_en) begin
        entries_d[free_idx].busy  = 1'b0;
        entries_d[free_idx].ready = 1'b0;
      end
      if (disp_en) begin
        entries_d[disp_idx] = '{busy: 1'b1, ready: 1'b0, rd: disp_rd, value: 32'h0,
                                is_br: disp_is_br, pred: disp_pred, taken: 1'b0,
                                alt_pc: disp_alt_pc};
      end
    end
  end

  // Entry storage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RoB_SIZE; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      entries_q <= entries_d;
    end
  end

  assign head_entry = entries_q[head_idx];
  assign q1_rdy     = entries_q[q1_idx].busy && entries_q[q1_idx].ready;
  assign q1_val     = q1_rdy ? entries_q[q1_idx].value : 32'h0;
  assign q2_rdy     = entries_q[q2_idx].busy && entries_q[q2_idx].ready;
  assign q2_val     = q2_rdy ? entries_q[q2_idx].value : 32'h0;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates entries for dispatch, captures CDB results,
// retires one ready head entry per cycle and flushes on a branch mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  input  logic                    DPRoB_en,
  input  logic [EX_REG_WIDTH-1:0] DPRoB_rd,
  input  logic                    DPRoB_is_br,
  input  logic                    DPRoB_pred,
  input  logic [31:0]             DPRoB_alt_pc,
  output logic [RoB_WIDTH-1:0]    RoBDP_index,
  output logic                    RoBDP_full,
  input  logic [RoB_WIDTH-1:0]    DPRoB_q1,
  input  logic [RoB_WIDTH-1:0]    DPRoB_q2,
  output logic                    RoBDP_rdy1,
  output logic                    RoBDP_rdy2,
  output logic [31:0]             RoBDP_val1,
  output logic [31:0]             RoBDP_val2,
  input  logic                    CDB_en,
  input  logic [RoB_WIDTH-1:0]    CDB_index,
  input  logic [31:0]             CDB_value,
  input  logic                    CDB_taken,
  output logic                    RoBRF_en,
  output logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
  output logic [EX_REG_WIDTH-1:0] RoBRF_rd,
  output logic [31:0]             RoBRF_value,
  output logic                    RoBRF_pre_judge,
  output logic                    RoBIF_redirect,
  output logic [31:0]             RoBIF_pc
);

  logic [RoB_WIDTH-1:0]    head_q, head_d, tail_q, tail_d;
  logic [RoB_WIDTH:0]      count_q, count_d;
  rob_entry_t              head_e;
  logic                    full, do_disp, do_cdb, do_commit, mispredict;

  logic                    rf_en_q, rf_en_d;
  logic [RoB_WIDTH-1:0]    rf_idx_q, rf_idx_d;
  logic [EX_REG_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [31:0]             rf_value_q, rf_value_d;
  logic                    pre_judge_q, pre_judge_d;
  logic                    redirect_q, redirect_d;
  logic [31:0]             pc_q, pc_d;

  rob_entry_array u_entries (
    .clk         (Sys_clk),
    .rst         (Sys_rst),
    .disp_en     (do_disp),
    .disp_idx    (tail_q),
    .disp_rd     (DPRoB_rd),
    .disp_is_br  (DPRoB_is_br),
    .disp_pred   (DPRoB_pred),
    .disp_alt_pc (DPRoB_alt_pc),
    .cdb_en      (do_cdb),
    .cdb_idx     (CDB_index),
    .cdb_value   (CDB_value),
    .cdb_taken   (CDB_taken),
    .free_en     (do_commit && !mispredict),
    .free_idx    (head_q),
    .flush       (mispredict),
    .head_idx    (head_q),
    .head_entry  (head_e),
    .q1_idx      (DPRoB_q1),
    .q1_rdy      (RoBDP_rdy1),
    .q1_val      (RoBDP_val1),
    .q2_idx      (DPRoB_q2),
    .q2_rdy      (RoBDP_rdy2),
    .q2_val      (RoBDP_val2)
  );

  // Qualify this cycle's dispatch, writeback and commit; a flush discards the rest
  always_comb begin
    full       = (count_q == (RoB_WIDTH+1)'(RoB_SIZE));
    do_commit  = Sys_rdy && head_e.busy && head_e.ready;
    mispredict = do_commit && head_e.is_br && (head_e.taken != head_e.pred);
    do_disp    = Sys_rdy && DPRoB_en && !full && !mispredict;
    do_cdb     = Sys_rdy && CDB_en && !mispredict;
  end

  // Pointer and occupancy update
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_disp)   tail_d = tail_q + RoB_WIDTH'(1);
      if (do_commit) head_d = head_q + RoB_WIDTH'(1);
      case ({do_disp, do_commit})
        2'b10:   count_d = count_q + (RoB_WIDTH+1)'(1);
        2'b01:   count_d = count_q - (RoB_WIDTH+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Commit port values for next cycle; idle unless the head retires
  always_comb begin
    rf_en_d     = 1'b0;
    rf_idx_d    = '0;
    rf_rd_d     = NON_REG;
    rf_value_d  = 32'h0;
    pre_judge_d = 1'b1;
    redirect_d  = 1'b0;
    pc_d        = 32'h0;
    if (do_commit) begin
      rf_en_d    = 1'b1;
      rf_idx_d   = head_q;
      rf_rd_d    = head_e.is_br ? NON_REG : head_e.rd;
      rf_value_d = head_e.value;
      if (mispredict) begin
        pre_judge_d = 1'b0;
        redirect_d  = 1'b1;
        pc_d        = head_e.alt_pc;
      end
    end
  end

  // Pointer, count and commit output registers
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rf_en_q     <= 1'b0;
      rf_idx_q    <= '0;
      rf_rd_q     <= NON_REG;
      rf_value_q  <= 32'h0;
      pre_judge_q <= 1'b1;
      redirect_q  <= 1'b0;
      pc_q        <= 32'h0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rf_en_q     <= rf_en_d;
      rf_idx_q    <= rf_idx_d;
      rf_rd_q     <= rf_rd_d;
      rf_value_q  <= rf_value_d;
      pre_judge_q <= pre_judge_d;
      redirect_q  <= redirect_d;
      pc_q        <= pc_d;
    end
  end

  // Dispatching into a full queue is a dispatcher bug; the request is dropped
  a_no_dispatch_when_full: assert property (@(posedge Sys_clk) disable iff (Sys_rst)
    !(Sys_rdy && DPRoB_en && full));

  assign RoBDP_index     = tail_q;
  assign RoBDP_full      = full;
  assign RoBRF_en        = rf_en_q;
  assign RoBRF_RoB_index = rf_idx_q;
  assign RoBRF_rd        = rf_rd_q;
  assign RoBRF_value     = rf_value_q;
  assign RoBRF_pre_judge = pre_judge_q;
  assign RoBIF_redirect  = redirect_q;
  assign RoBIF_pc        = pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, hand sequences
// for reset/flush/full corners, and randomized traffic against a queue model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        Sys_clk, Sys_rst, Sys_rdy;
  logic        DPRoB_en;
  logic [5:0]  DPRoB_rd;
  logic        DPRoB_is_br, DPRoB_pred;
  logic [31:0] DPRoB_alt_pc;
  logic [7:0]  RoBDP_index;
  logic        RoBDP_full;
  logic [7:0]  DPRoB_q1, DPRoB_q2;
  logic        RoBDP_rdy1, RoBDP_rdy2;
  logic [31:0] RoBDP_val1, RoBDP_val2;
  logic        CDB_en;
  logic [7:0]  CDB_index;
  logic [31:0] CDB_value;
  logic        CDB_taken;
  logic        RoBRF_en;
  logic [7:0]  RoBRF_RoB_index;
  logic [5:0]  RoBRF_rd;
  logic [31:0] RoBRF_value;
  logic        RoBRF_pre_judge, RoBIF_redirect;
  logic [31:0] RoBIF_pc;

  reorder_buffer dut (
    .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
    .DPRoB_en(DPRoB_en), .DPRoB_rd(DPRoB_rd), .DPRoB_is_br(DPRoB_is_br),
    .DPRoB_pred(DPRoB_pred), .DPRoB_alt_pc(DPRoB_alt_pc),
    .RoBDP_index(RoBDP_index), .RoBDP_full(RoBDP_full),
    .DPRoB_q1(DPRoB_q1), .DPRoB_q2(DPRoB_q2),
    .RoBDP_rdy1(RoBDP_rdy1), .RoBDP_rdy2(RoBDP_rdy2),
    .RoBDP_val1(RoBDP_val1), .RoBDP_val2(RoBDP_val2),
    .CDB_en(CDB_en), .CDB_index(CDB_index), .CDB_value(CDB_value), .CDB_taken(CDB_taken),
    .RoBRF_en(RoBRF_en), .RoBRF_RoB_index(RoBRF_RoB_index), .RoBRF_rd(RoBRF_rd),
    .RoBRF_value(RoBRF_value), .RoBRF_pre_judge(RoBRF_pre_judge),
    .RoBIF_redirect(RoBIF_redirect), .RoBIF_pc(RoBIF_pc)
  );

  initial begin
    Sys_clk = 1'b0;
    forever #5 Sys_clk = ~Sys_clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: plain in-order queue ----------------
  typedef struct {
    logic [7:0]  idx;
    logic [5:0]  rd;
    logic [31:0] value;
    bit          ready;
    bit          is_br, pred, taken;
    logic [31:0] alt_pc;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_tail;

  logic        e_en, e_pj, e_redir, e_full, e_rdy1, e_rdy2;
  logic [7:0]  e_idx, e_index;
  logic [5:0]  e_rd;
  logic [31:0] e_val, e_pc, e_val1, e_val2;

  function automatic void mquery(input logic [7:0] q, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = 32'h0;
    foreach (mq[i]) if (mq[i].idx == q && mq[i].ready) begin
      r = 1'b1;
      v = mq[i].value;
    end
  endfunction

  function automatic void model_step();
    bit     commit, mis, was_full;
    m_ent_t ne;
    e_en = 1'b0; e_idx = 8'h0; e_rd = NON_REG; e_val = 32'h0;
    e_pj = 1'b1; e_redir = 1'b0; e_pc = 32'h0;
    if (Sys_rdy) begin
      was_full = (mq.size() == 256);
      commit   = (mq.size() > 0) && mq[0].ready;
      mis      = commit && mq[0].is_br && (mq[0].taken != mq[0].pred);
      if (commit) begin
        e_en  = 1'b1;
        e_idx = mq[0].idx;
        e_rd  = mq[0].is_br ? NON_REG : mq[0].rd;
        e_val = mq[0].value;
        if (mis) begin
          e_pj = 1'b0; e_redir = 1'b1; e_pc = mq[0].alt_pc;
        end
      end
      if (mis) begin
        mq.delete();
        m_tail = 0;
      end else begin
        if (CDB_en) foreach (mq[i]) if (mq[i].idx == CDB_index) begin
          mq[i].ready = 1'b1;
          mq[i].value = CDB_value;
          mq[i].taken = CDB_taken;
        end
        if (commit) void'(mq.pop_front());
        if (DPRoB_en && !was_full) begin
          ne.idx = 8'(m_tail); ne.rd = DPRoB_rd; ne.value = 32'h0; ne.ready = 1'b0;
          ne.is_br = DPRoB_is_br; ne.pred = DPRoB_pred; ne.taken = 1'b0;
          ne.alt_pc = DPRoB_alt_pc;
          mq.push_back(ne);
          m_tail = (m_tail + 1) % 256;
        end
      end
    end
    e_full  = (mq.size() == 256);
    e_index = 8'(m_tail);
    mquery(DPRoB_q1, e_rdy1, e_val1);
    mquery(DPRoB_q2, e_rdy2, e_val2);
  endfunction

  task automatic idle_inputs();
    Sys_rdy = 1'b1; DPRoB_en = 1'b0; DPRoB_rd = 6'd0; DPRoB_is_br = 1'b0;
    DPRoB_pred = 1'b0; DPRoB_alt_pc = 32'h0; CDB_en = 1'b0; CDB_index = 8'd0;
    CDB_value = 32'h0; CDB_taken = 1'b0; DPRoB_q1 = 8'd0; DPRoB_q2 = 8'd0;
  endtask

  task automatic tick();
    @(posedge Sys_clk);
    #1;
  endtask

  // One clock with the model predicting every observable output
  task automatic run_cycle();
    model_step();
    tick();
    chk("commit_en", RoBRF_en, e_en);
    if (e_en) begin
      chk("commit_idx", RoBRF_RoB_index, e_idx);
      chk("commit_rd", RoBRF_rd, e_rd);
      chk("commit_val", RoBRF_value, e_val);
    end
    chk("pre_judge", RoBRF_pre_judge, e_pj);
    chk("redirect", RoBIF_redirect, e_redir);
    if (e_redir) chk("redirect_pc", RoBIF_pc, e_pc);
    chk("full", RoBDP_full, e_full);
    chk("alloc_index", RoBDP_index, e_index);
    chk("rdy1", RoBDP_rdy1, e_rdy1);
    chk("val1", RoBDP_val1, e_val1);
    chk("rdy2", RoBDP_rdy2, e_rdy2);
    chk("val2", RoBDP_val2, e_val2);
  endtask

  // Reset asserted between clock edges must take effect immediately
  task automatic do_reset(input string tag);
    idle_inputs();
    Sys_rst = 1'b1;
    #2;
    chk({tag, "_rst_en"}, RoBRF_en, 32'd0);
    chk({tag, "_rst_pj"}, RoBRF_pre_judge, 32'd1);
    chk({tag, "_rst_redir"}, RoBIF_redirect, 32'd0);
    chk({tag, "_rst_rd"}, RoBRF_rd, 32'(NON_REG));
    chk({tag, "_rst_val"}, RoBRF_value, 32'd0);
    chk({tag, "_rst_full"}, RoBDP_full, 32'd0);
    chk({tag, "_rst_index"}, RoBDP_index, 32'd0);
    mq.delete();
    m_tail = 0;
    @(negedge Sys_clk);
    Sys_rst = 1'b0;
    tick();
  endtask

  typedef struct {
    logic de; logic [5:0] rd; logic br, pr; logic [31:0] apc;
    logic ce; logic [7:0] ci; logic [31:0] cv; logic ct;
    logic [7:0] q1;
    logic x_en; logic [7:0] x_idx; logic [5:0] x_rd; logic [31:0] x_val;
    logic x_pj; logic [7:0] x_index; logic x_rdy1; logic [31:0] x_val1;
  } vec_t;

  vec_t tbl[17];

  initial begin
    Sys_rst = 1'b0;
    idle_inputs();
    #1;
    do_reset("init");

    // inputs for one cycle | expected state right after that clock edge
    tbl[0]  = '{1'b1,6'd5,1'b0,1'b0,32'h0,  1'b0,8'd0,32'h0,1'b0,    8'd0, 1'b0,8'd0,6'd0,32'h0,1'b1,8'd1,1'b0,32'h0};
    tbl[1]  = '{1'b0,6'd0,1'b0,1'b0,32'h0,  1'b1,8'd0,32'h1234,1'b0, 8'd0, 1'b0,8'd0,6'd0,32'h0,1'b1,8'd1,1'b1,32'h1234};
    tbl[2]  = '{1'b0,6'd0,1'b0,1'b0,32'h0,  1'b0,8'd0,32'h0,1'b0,    8'd0, 1'b1,8'd0,6'd5,32'h1234,1'b1,8'd1,1'b0,32'h0};
    tbl[3]  = '{1'b0,6'd0,1'b0,1'b0,32'h0,  1'b0,8'd0,32'h0,1'b0,    8'd0, 1'b0,8'd0,6'd0,32'h0,1'b1,8'd1,1'b0,32'h0};
    tbl[4]  = '{1'b1,6'd1,1'b0,1'b0,32'h0,  1'b0,8'd0,32'h0,1'b0,    8'd0, 1'b0,8'd0,6'd0,32'h0,1'b1,8'd2,1'b0,32'h0};
    tbl[5]  = '{1'b1,6'd2,1'b0,1'b0,32'h0,  1'b0,8'd0,32'h0,1'b0,    8'd0, 1'b0,8'd0,6'd0,32'h0,1'b1,8'd3,1'b0,32'h0};
    tbl[6]  = '{1'b0,6'd0,1'b0,1'b0,32'h0,  1'b1,8'd2,32'hB,1'b0,    8'd2, 1'b0,8'd0,6'd0,32'h0,1'b1,8'd3,1'b1,32'hB};
    tbl[7]  = '{1'b0,6'd0,1'b0,1'b0,32'h0,  1'b1,8'd1,32'hA,1'b0,    8'd2, 1'b0,8'd0,6'd0,32'h0,1'b1,8'd3,1'b1,32'hB};
    tbl[8]  = '{1'b0,6'd0,1'b0,1'b0,32'h0,  1'b0,8'd0,32'h0,1'b0,    8'd1, 1'b1,8'd1,6'd1,32'hA,1'b1,8'd3,1'b0,32'h0};
    tbl[9]  = '{1'b0,6'd0,1'b0,1'b0,32'h0,  1'b0,8'd0,32'h0,1'b0,    8'd2, 1'b1,8'd2,6'd2,32'hB,1'b1,8'd3,1'b0,32'h0};
    tbl[10] = '{1'b0,6'd0,1'b0,1'b0,32'h0,  1'b0,8'd0,32'h0,1'b0,    8'd0, 1'b0,8'd0,6'd0,32'h0,1'b1,8'd3,1'b0,32'h0};
    tbl[11] = '{1'b1,6'd7,1'b0,1'b0,32'h0,  1'b0,8'd0,32'h0,1'b0,    8'd3, 1'b0,8'd0,6'd0,32'h0,1'b1,8'd4,1'b0,32'h0};
    tbl[12] = '{1'b0,6'd0,1'b0,1'b0,32'h0,  1'b1,8'd3,32'h7,1'b0,    8'd3, 1'b0,8'd0,6'd0,32'h0,1'b1,8'd4,1'b1,32'h7};
    tbl[13] = '{1'b0,6'd0,1'b0,1'b0,32'h0,  1'b0,8'd0,32'h0,1'b0,    8'd3, 1'b1,8'd3,6'd7,32'h7,1'b1,8'd4,1'b0,32'h0};
    tbl[14] = '{1'b1,6'd9,1'b1,1'b1,32'h40, 1'b0,8'd0,32'h0,1'b0,    8'd0, 1'b0,8'd0,6'd0,32'h0,1'b1,8'd5,1'b0,32'h0};
    tbl[15] = '{1'b0,6'd0,1'b0,1'b0,32'h0,  1'b1,8'd4,32'h0,1'b1,    8'd0, 1'b0,8'd0,6'd0,32'h0,1'b1,8'd5,1'b0,32'h0};
    tbl[16] = '{1'b0,6'd0,1'b0,1'b0,32'h0,  1'b0,8'd0,32'h0,1'b0,    8'd0, 1'b1,8'd4,6'h20,32'h0,1'b1,8'd5,1'b0,32'h0};

    for (int i = 0; i < 17; i++) begin
      idle_inputs();
      DPRoB_en = tbl[i].de; DPRoB_rd = tbl[i].rd; DPRoB_is_br = tbl[i].br;
      DPRoB_pred = tbl[i].pr; DPRoB_alt_pc = tbl[i].apc;
      CDB_en = tbl[i].ce; CDB_index = tbl[i].ci; CDB_value = tbl[i].cv; CDB_taken = tbl[i].ct;
      DPRoB_q1 = tbl[i].q1;
      tick();
      chk($sformatf("vec%0d_en", i), RoBRF_en, tbl[i].x_en);
      if (tbl[i].x_en) begin
        chk($sformatf("vec%0d_idx", i), RoBRF_RoB_index, tbl[i].x_idx);
        chk($sformatf("vec%0d_rd", i), RoBRF_rd, tbl[i].x_rd);
        chk($sformatf("vec%0d_val", i), RoBRF_value, tbl[i].x_val);
      end
      chk($sformatf("vec%0d_pj", i), RoBRF_pre_judge, tbl[i].x_pj);
      chk($sformatf("vec%0d_redir", i), RoBIF_redirect, 32'd0);
      chk($sformatf("vec%0d_index", i), RoBDP_index, tbl[i].x_index);
      chk($sformatf("vec%0d_rdy1", i), RoBDP_rdy1, tbl[i].x_rdy1);
      chk($sformatf("vec%0d_val1", i), RoBDP_val1, tbl[i].x_val1);
    end

    // Reset mid-run with three busy entries (5,6,7), landing on a commit pulse
    for (int i = 1; i <= 3; i++) begin
      idle_inputs(); DPRoB_en = 1'b1; DPRoB_rd = 6'(i); tick();
    end
    idle_inputs(); CDB_en = 1'b1; CDB_index = 8'd5; CDB_value = 32'h55; tick();
    idle_inputs(); tick();
    chk("pre_rst_en", RoBRF_en, 32'd1);
    chk("pre_rst_index", RoBDP_index, 32'd8);
    do_reset("mid");

    // Mispredicted branch with two younger ready entries behind it
    idle_inputs(); DPRoB_en = 1'b1; DPRoB_rd = 6'd3; DPRoB_is_br = 1'b1;
    DPRoB_pred = 1'b0; DPRoB_alt_pc = 32'h80; run_cycle();
    idle_inputs(); DPRoB_en = 1'b1; DPRoB_rd = 6'd4; run_cycle();
    idle_inputs(); DPRoB_en = 1'b1; DPRoB_rd = 6'd6; run_cycle();
    idle_inputs(); CDB_en = 1'b1; CDB_index = 8'd1; CDB_value = 32'h11; run_cycle();
    idle_inputs(); CDB_en = 1'b1; CDB_index = 8'd2; CDB_value = 32'h22; run_cycle();
    idle_inputs(); CDB_en = 1'b1; CDB_index = 8'd0; CDB_taken = 1'b1; run_cycle();
    idle_inputs(); DPRoB_en = 1'b1; DPRoB_rd = 6'd9; run_cycle();
    chk("flush_en", RoBRF_en, 32'd1);
    chk("flush_pj", RoBRF_pre_judge, 32'd0);
    chk("flush_redir", RoBIF_redirect, 32'd1);
    chk("flush_pc", RoBIF_pc, 32'h80);
    chk("flush_rd", RoBRF_rd, 32'(NON_REG));
    chk("flush_drop_dispatch", RoBDP_index, 32'd0);
    idle_inputs(); run_cycle();
    chk("post_flush_pj", RoBRF_pre_judge, 32'd1);
    chk("post_flush_redir", RoBIF_redirect, 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); run_cycle();
      chk("younger_never_commit", RoBRF_en, 32'd0);
    end

    // Fill all 256 entries, then retire one and allocate one
    do_reset("fill");
    for (int i = 0; i < 256; i++) begin
      idle_inputs(); DPRoB_en = 1'b1; DPRoB_rd = 6'(i % 32); run_cycle();
    end
    chk("fill_full", RoBDP_full, 32'd1);
    chk("fill_index_wrap", RoBDP_index, 32'd0);
    idle_inputs(); CDB_en = 1'b1; CDB_index = 8'd0; CDB_value = 32'h99; run_cycle();
    idle_inputs(); run_cycle();
    chk("fill_commit_en", RoBRF_en, 32'd1);
    chk("fill_not_full", RoBDP_full, 32'd0);
    idle_inputs(); DPRoB_en = 1'b1; DPRoB_rd = 6'd1; run_cycle();
    chk("refill_full", RoBDP_full, 32'd1);
    chk("refill_index", RoBDP_index, 32'd1);

    // Randomized traffic against the queue model
    do_reset("rand");
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      Sys_rdy = ($urandom_range(0, 19) != 0);
      if (mq.size() < 256 && $urandom_range(0, 9) < 6) begin
        DPRoB_en     = 1'b1;
        DPRoB_rd     = 6'($urandom_range(0, 63));
        DPRoB_is_br  = ($urandom_range(0, 9) == 0);
        DPRoB_pred   = 1'($urandom_range(0, 1));
        DPRoB_alt_pc = $urandom;
      end
      if ($urandom_range(0, 9) < 6) begin
        CDB_en = 1'b1;
        if (mq.size() > 0 && $urandom_range(0, 7) != 0)
          CDB_index = mq[$urandom_range(0, mq.size() - 1)].idx;
        else
          CDB_index = 8'($urandom_range(0, 255));
        CDB_value = $urandom;
        CDB_taken = 1'($urandom_range(0, 1));
      end
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
        DPRoB_q1 = mq[$urandom_range(0, mq.size() - 1)].idx;
      else
        DPRoB_q1 = 8'($urandom_range(0, 255));
      DPRoB_q2 = 8'($urandom_range(0, 15));
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement queue between the dispatcher and the register file.
- Allocates one entry per dispatched instruction and returns its RoB index, which the register file records as the rd dependency.
- Captures execution results from the common data bus (CDB) and retires the head entry in order, one per cycle, driving the register-file commit port.
- Detects branch mispredicts at commit, pulses the flush (pre_judge low) and supplies the redirect PC.

Parameters:
- RoB_WIDTH, 8, index width; depth RoB_SIZE = 1<<RoB_WIDTH.
- EX_REG_WIDTH, 6, extended register id; bit5 set = no register.
- NON_REG, 6'b100000, "no destination register" encoding.

Ports:
- Sys_clk  in  1  clock, posedge.
- Sys_rst  in  1  asynchronous, active-high reset.
- Sys_rdy  in  1  global enable; low freezes all state.
- DPRoB_en  in  1  allocate one entry this cycle.
- DPRoB_rd  in  6  destination register, or NON_REG.
- DPRoB_is_br  in  1  entry is a conditional branch.
- DPRoB_pred  in  1  predicted taken.
- DPRoB_alt_pc  in  32  PC to fetch if the prediction proves wrong.
- RoBDP_index  out  RoB_WIDTH  index the next allocation receives (= tail).
- RoBDP_full  out  1  no free entry.
- DPRoB_q1, DPRoB_q2  in  RoB_WIDTH each  operand-forwarding query indices.
- RoBDP_rdy1, RoBDP_rdy2  out  1 each  queried entry is busy and ready.
- RoBDP_val1, RoBDP_val2  out  32 each  queried entry value; 0 when not ready.
- CDB_en  in  1  result broadcast valid.
- CDB_index  in  RoB_WIDTH  entry the result belongs to.
- CDB_value  in  32  result value.
- CDB_taken  in  1  actual branch outcome; ignored for non-branch entries.
- RoBRF_en  out  1  commit pulse.
- RoBRF_RoB_index  out  RoB_WIDTH  retiring entry index.
- RoBRF_rd  out  6  retiring destination register.
- RoBRF_value  out  32  retiring value.
- RoBRF_pre_judge  out  1  1 = normal; 0 = mispredict flush, one cycle.
- RoBIF_redirect  out  1  fetch redirect pulse, coincident with pre_judge=0.
- RoBIF_pc  out  32  redirect target.

Behaviour:
- Reset, asynchronous: head=tail=count=0; all busy/ready bits clear.
  - Outputs at reset: RoBRF_en=0, RoBRF_pre_judge=1, RoBIF_redirect=0, RoBRF_rd=NON_REG, other data outputs 0.
- Per-entry state: busy, ready, rd, value, is_br, pred, taken, alt_pc.
- Full and index outputs: RoBDP_full = (count == RoB_SIZE); RoBDP_index = tail. Both combinational.
- Dispatch, when DPRoB_en && !full:
  - Write entry[tail] with busy=1, ready=0.
  - tail increments with wrap modulo RoB_SIZE.
  - DPRoB_en while full is a protocol error: ignored, with an assertion.
- Writeback, when CDB_en && entry[CDB_index].busy:
  - Set ready=1; store value and taken.
  - CDB to a non-busy entry is ignored.
- Commit decision, evaluated from registered state each cycle (Sys_rdy=1, no flush pending):
  - Commit occurs when entry[head] is busy and ready.
  - Next cycle, registered outputs: RoBRF_en=1, index=head, rd, value.
  - Entry is freed and head increments with wrap.
  - A CDB write to the head entry becomes committable the following cycle. Commit latency from CDB is 1 cycle to decision, outputs registered one cycle later.
- Mispredict: the committing entry has is_br && (taken != pred).
  - Commit pulse: RoBRF_en=1, RoBRF_rd=NON_REG, RoBRF_pre_judge=0, RoBIF_redirect=1, RoBIF_pc=alt_pc.
  - In the same state update, all busy bits clear and head=tail=count=0.
  - Any dispatch or CDB in that update cycle is discarded.
  - pre_judge returns to 1 the next cycle.
- Correct branches commit with rd=NON_REG and pre_judge=1.
- All pulses last exactly one cycle. Outputs revert to en=0, pre_judge=1, redirect=0 when nothing commits.
- Count update with simultaneous dispatch and commit: count unchanged. Dispatch when full with a commit in the same cycle is still refused, because full is the registered count.
- Empty queue: head not busy, so no commit.
- Forwarding queries: combinational. rdyN = busy[qN] && ready[qN]; valN = value[qN] when ready, else 0. The query does not see a same-cycle CDB.
- Sys_rdy=0: no state change and commit outputs forced idle. Reset still acts immediately.

Decomposition:
- Shared package holds: NON_REG, RoB_WIDTH, EX_REG_WIDTH, the NON_DEP encoding, and the RoB entry record typedef. These are shared with the register file and dispatcher.
- One natural sub-module, rob_entry_array: entry storage with dispatch/CDB write ports and combinational read ports for head and the two queries.
- Pointer, count and commit FSM logic stay in reorder_buffer.

Test Plan:
- Reset mid-run with 3 busy entries, Sys_rst asserted between edges -> immediately en=0, pre_judge=1, full=0, RoBDP_index=0.
- Dispatch rd=5 (index 0), CDB index 0 value 0x1234 -> next cycle commit decision; following cycle RoBRF_en=1, index 0, rd=5, value 0x1234 for one cycle.
- Dispatch A, B; CDB B then A -> B does not commit before A; commits are in order, indices 0 then 1 on consecutive cycles.
- Fill 256 entries -> full=1 and index wraps to 0. Commit one and dispatch one -> count stays 256, tail=1.
- Branch pred=0, CDB taken=1, alt_pc=0x80, with two younger busy entries -> pre_judge=0, redirect=1, pc=0x80 for one cycle. Afterwards count=0, younger entries never commit.
- Query q1=3 with entry 3 ready, value 7 -> rdy1=1, val1=7. After entry 3 commits -> rdy1=0, val1=0.
